// File: rtl/memory_port_arbiter_pkg.sv
// Shared defaults and master indices for the two-master RAM port arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 13;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 6144;

    localparam int M0 = 0;
    localparam int M1 = 1;

    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/memory_port_arbiter_rr_arbiter2.sv
// Two-requester round-robin arbiter: combinational grant, pointer remembers
// the winner of the last contested cycle.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ready,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic       rr_ptr_r;
    logic [1:0] grant_s;

    // Grant selection: a lone requester wins, a contest goes to the last loser
    always_comb begin
        grant_s = 2'b00;
        case (req)
            2'b01:   grant_s = 2'b01;
            2'b10:   grant_s = 2'b10;
            2'b11:   grant_s = rr_ptr_r ? 2'b01 : 2'b10;
            default: grant_s = 2'b00;
        endcase
    end

    // Pointer update only on a contested cycle that actually accepts
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_r <= 1'b0;
        end else if (ready && (req == 2'b11)) begin
            rr_ptr_r <= grant_s[M1];
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    assign grant = grant_s;

endmodule

// File: rtl/memory_port_arbiter.sv
// Two-master Avalon-MM-style front end for the single-port on-chip RAM:
// round-robin grant, one access per cycle, 1-cycle read return, range check.
module memory_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int ADDR_W = ADDR_W_DEF,
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int DEPTH  = DEPTH_DEF,
    localparam int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic              m0_readdatavalid,
    output logic [DATA_W-1:0] m0_readdata,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic              m1_readdatavalid,
    output logic [DATA_W-1:0] m1_readdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic              oor_err,
    output logic              oor_sticky
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic              ready_r;
    logic [1:0]        rd_pend_r;
    logic              rd_oor_r;
    logic              oor_sticky_r;

    logic [1:0]        req_s;
    logic [1:0]        grant_s;
    logic [1:0]        accept_s;
    logic [1:0]        rd_accept_s;
    logic              any_accept_s;
    logic              in_range_s;
    logic              oor_err_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [BE_W-1:0]   sel_be_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic              sel_write_s;
    logic [DATA_W-1:0] rd_data_s;

    assign req_s        = {m1_read | m1_write, m0_read | m0_write};
    assign accept_s     = req_s & grant_s & {2{ready_r}};
    assign any_accept_s = |accept_s;
    // A combined read+write is a write, so it never opens a read return slot
    assign rd_accept_s  = accept_s & {m1_read & ~m1_write, m0_read & ~m0_write};

    rr_arbiter2 u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .ready   (ready_r),
        .req     (req_s),
        .grant   (grant_s)
    );

    // Steer the accepted master onto the RAM bus; idle bus is all zero
    always_comb begin
        sel_addr_s  = {ADDR_W{1'b0}};
        sel_be_s    = {BE_W{1'b0}};
        sel_wdata_s = {DATA_W{1'b0}};
        sel_write_s = 1'b0;
        if (accept_s[M1]) begin
            sel_addr_s  = m1_address;
            sel_be_s    = m1_byteenable;
            sel_wdata_s = m1_writedata;
            sel_write_s = m1_write;
        end else if (accept_s[M0]) begin
            sel_addr_s  = m0_address;
            sel_be_s    = m0_byteenable;
            sel_wdata_s = m0_writedata;
            sel_write_s = m0_write;
        end else begin
            sel_addr_s  = {ADDR_W{1'b0}};
            sel_be_s    = {BE_W{1'b0}};
            sel_wdata_s = {DATA_W{1'b0}};
            sel_write_s = 1'b0;
        end
    end

    assign in_range_s = ({1'b0, sel_addr_s} < DEPTH_C);
    assign oor_err_s  = any_accept_s & ~in_range_s;

    // Out-of-range reads return zero instead of whatever the RAM drives
    always_comb begin
        rd_data_s = {DATA_W{1'b0}};
        if (rd_oor_r) begin
            rd_data_s = {DATA_W{1'b0}};
        end else begin
            rd_data_s = mem_readdata;
        end
    end

    // Ready flag holds both masters off for one cycle after reset release
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_r <= 1'b0;
        end else begin
            ready_r <= 1'b1;
        end
    end

    // Pending-read pipeline matching the RAM's one-cycle read latency
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend_r <= 2'b00;
            rd_oor_r  <= 1'b0;
        end else begin
            rd_pend_r <= rd_accept_s;
            rd_oor_r  <= ~in_range_s;
        end
    end

    // Sticky out-of-range flag, cleared only by reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            oor_sticky_r <= 1'b0;
        end else begin
            oor_sticky_r <= oor_sticky_r | oor_err_s;
        end
    end

    assign m0_waitrequest   = ~ready_r | (req_s[M0] & ~grant_s[M0]);
    assign m1_waitrequest   = ~ready_r | (req_s[M1] & ~grant_s[M1]);
    assign m0_readdatavalid = rd_pend_r[M0];
    assign m1_readdatavalid = rd_pend_r[M1];
    assign m0_readdata      = rd_data_s;
    assign m1_readdata      = rd_data_s;

    assign mem_address    = sel_addr_s;
    assign mem_byteenable = sel_be_s;
    assign mem_writedata  = sel_wdata_s;
    assign mem_write      = sel_write_s;
    assign mem_chipselect = any_accept_s & in_range_s;
    assign oor_err        = oor_err_s;
    assign oor_sticky     = oor_sticky_r;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter with a behavioural 6144x32 RAM
// (registered address, unregistered data) behind the arbiter.
module tb_memory_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [12:0] m0_address = 13'h0, m1_address = 13'h0;
    logic [3:0]  m0_byteenable = 4'h0, m1_byteenable = 4'h0;
    logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
    logic [31:0] m0_writedata = 32'h0, m1_writedata = 32'h0;
    logic        m0_waitrequest, m0_readdatavalid, m1_waitrequest, m1_readdatavalid;
    logic [31:0] m0_readdata, m1_readdata;
    logic [12:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write;
    logic [31:0] mem_writedata, mem_readdata;
    logic        oor_err, oor_sticky;

    logic [31:0] ram [0:6143];
    logic [12:0] rd_addr_q = 13'h0;
    logic        ram_init = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    memory_port_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdatavalid(m0_readdatavalid), .m0_readdata(m0_readdata),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdatavalid(m1_readdatavalid), .m1_readdata(m1_readdata),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
        .oor_err(oor_err), .oor_sticky(oor_sticky)
    );

    // RAM model with a known background pattern so zeroed OOR data is visible
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 6144; i++) ram[i] <= 32'(i) ^ 32'hA5A50000;
        end else if (mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end
            rd_addr_q <= mem_address;
        end
    end
    assign mem_readdata = ram[rd_addr_q];

    typedef struct {
        logic [1:0]  who;
        logic        rd, wr;
        logic [12:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        e_cs, e_we;
        logic [12:0] e_addr;
        logic        e_oor, e_st, e_v0, e_v1;
        logic [31:0] e_rd;
    } vec_t;

    vec_t tbl [0:17];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        m0_read = 1'b0; m0_write = 1'b0; m0_address = 13'h0; m0_byteenable = 4'h0; m0_writedata = 32'h0;
        m1_read = 1'b0; m1_write = 1'b0; m1_address = 13'h0; m1_byteenable = 4'h0; m1_writedata = 32'h0;
    endtask

    logic        exp_win;
    logic        pv, pw;
    logic [12:0] pa;
    int          n0, n1, rdv_count;

    initial begin
        tbl[0]  = '{2'd0, 1'b0, 1'b0, 13'h0000, 4'h0, 32'h0,        1'b0, 1'b0, 13'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[1]  = '{2'd1, 1'b0, 1'b1, 13'h0010, 4'hF, 32'hDEADBEEF, 1'b1, 1'b1, 13'h0010, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[2]  = '{2'd1, 1'b1, 1'b0, 13'h0010, 4'hF, 32'h0,        1'b1, 1'b0, 13'h0010, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[3]  = '{2'd0, 1'b0, 1'b0, 13'h0000, 4'h0, 32'h0,        1'b0, 1'b0, 13'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
        tbl[4]  = '{2'd2, 1'b0, 1'b1, 13'h0020, 4'hF, 32'hFFFFFFFF, 1'b1, 1'b1, 13'h0020, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[5]  = '{2'd2, 1'b0, 1'b1, 13'h0020, 4'h5, 32'h11223344, 1'b1, 1'b1, 13'h0020, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[6]  = '{2'd1, 1'b1, 1'b0, 13'h0020, 4'hF, 32'h0,        1'b1, 1'b0, 13'h0020, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[7]  = '{2'd0, 1'b0, 1'b0, 13'h0000, 4'h0, 32'h0,        1'b0, 1'b0, 13'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFF22FF44};
        tbl[8]  = '{2'd2, 1'b1, 1'b0, 13'h1800, 4'hF, 32'h0,        1'b0, 1'b0, 13'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[9]  = '{2'd2, 1'b0, 1'b1, 13'h1838, 4'hF, 32'h5A5A5A5A, 1'b0, 1'b0, 13'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0};
        tbl[10] = '{2'd0, 1'b0, 1'b0, 13'h0000, 4'h0, 32'h0,        1'b0, 1'b0, 13'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[11] = '{2'd1, 1'b1, 1'b1, 13'h0030, 4'hF, 32'h12345678, 1'b1, 1'b1, 13'h0030, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[12] = '{2'd0, 1'b0, 1'b0, 13'h0000, 4'h0, 32'h0,        1'b0, 1'b0, 13'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[13] = '{2'd2, 1'b1, 1'b0, 13'h0030, 4'hF, 32'h0,        1'b1, 1'b0, 13'h0030, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[14] = '{2'd0, 1'b0, 1'b0, 13'h0000, 4'h0, 32'h0,        1'b0, 1'b0, 13'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 32'h12345678};
        tbl[15] = '{2'd1, 1'b0, 1'b1, 13'h17FF, 4'hF, 32'hCAFEF00D, 1'b1, 1'b1, 13'h17FF, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[16] = '{2'd1, 1'b1, 1'b0, 13'h17FF, 4'hF, 32'h0,        1'b1, 1'b0, 13'h17FF, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[17] = '{2'd0, 1'b0, 1'b0, 13'h0000, 4'h0, 32'h0,        1'b0, 1'b0, 13'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 32'hCAFEF00D};

        // Reset with m0 already requesting
        #2 reset_n = 1'b0;
        m0_read = 1'b1; m0_address = 13'h0010; m0_byteenable = 4'hF;
        @(posedge clk); #1 ram_init = 1'b0;
        @(negedge clk);
        chk1("rst_m0_wait", m0_waitrequest, 1'b1);
        chk1("rst_m1_wait", m1_waitrequest, 1'b1);
        chk1("rst_cs", mem_chipselect, 1'b0);
        chk1("rst_rdv", m0_readdatavalid, 1'b0);
        chk1("rst_sticky", oor_sticky, 1'b0);
        reset_n = 1'b1;
        #1;
        chk1("rel_m0_wait", m0_waitrequest, 1'b1);
        chk1("rel_cs", mem_chipselect, 1'b0);
        @(negedge clk);
        chk1("ready_m0_wait", m0_waitrequest, 1'b0);
        chk1("ready_cs", mem_chipselect, 1'b1);
        @(posedge clk); #1 idle_inputs();
        @(negedge clk);
        chk1("first_rdv", m0_readdatavalid, 1'b1);
        chk1("first_rdv_m1", m1_readdatavalid, 1'b0);

        // Table-driven single-master traffic
        for (int i = 0; i < 18; i++) begin
            @(posedge clk); #1;
            idle_inputs();
            if (tbl[i].who[0]) begin
                m0_read = tbl[i].rd; m0_write = tbl[i].wr; m0_address = tbl[i].addr;
                m0_byteenable = tbl[i].be; m0_writedata = tbl[i].wd;
            end
            if (tbl[i].who[1]) begin
                m1_read = tbl[i].rd; m1_write = tbl[i].wr; m1_address = tbl[i].addr;
                m1_byteenable = tbl[i].be; m1_writedata = tbl[i].wd;
            end
            @(negedge clk);
            chk1($sformatf("v%0d_w0", i), m0_waitrequest, 1'b0);
            chk1($sformatf("v%0d_w1", i), m1_waitrequest, 1'b0);
            chk1($sformatf("v%0d_cs", i), mem_chipselect, tbl[i].e_cs);
            chk1($sformatf("v%0d_oor", i), oor_err, tbl[i].e_oor);
            chk1($sformatf("v%0d_sticky", i), oor_sticky, tbl[i].e_st);
            chk1($sformatf("v%0d_rdv0", i), m0_readdatavalid, tbl[i].e_v0);
            chk1($sformatf("v%0d_rdv1", i), m1_readdatavalid, tbl[i].e_v1);
            if (tbl[i].e_cs) begin
                chk1($sformatf("v%0d_we", i), mem_write, tbl[i].e_we);
                chk32($sformatf("v%0d_addr", i), 32'(mem_address), 32'(tbl[i].e_addr));
            end
            if (tbl[i].e_v0) chk32($sformatf("v%0d_rd0", i), m0_readdata, tbl[i].e_rd);
            if (tbl[i].e_v1) chk32($sformatf("v%0d_rd1", i), m1_readdata, tbl[i].e_rd);
        end

        // Both masters reading continuously: m1 wins the first contest
        exp_win = 1'b1; pv = 1'b0; pw = 1'b0; pa = 13'h0; n0 = 0; n1 = 0; rdv_count = 0;
        for (int c = 0; c < 9; c++) begin
            @(posedge clk); #1;
            idle_inputs();
            if (c < 8) begin
                m0_read = 1'b1; m0_address = 13'(13'h100 + n0); m0_byteenable = 4'hF;
                m1_read = 1'b1; m1_address = 13'(13'h200 + n1); m1_byteenable = 4'hF;
            end
            @(negedge clk);
            if (c < 8) begin
                chk1($sformatf("rr%0d_w0", c), m0_waitrequest, exp_win);
                chk1($sformatf("rr%0d_w1", c), m1_waitrequest, ~exp_win);
                chk32($sformatf("rr%0d_addr", c), 32'(mem_address),
                      exp_win ? 32'(13'h200 + n1) : 32'(13'h100 + n0));
            end
            chk1($sformatf("rr%0d_rdv0", c), m0_readdatavalid, pv & ~pw);
            chk1($sformatf("rr%0d_rdv1", c), m1_readdatavalid, pv & pw);
            if (pv) chk32($sformatf("rr%0d_data", c), pw ? m1_readdata : m0_readdata,
                          32'(pa) ^ 32'hA5A50000);
            rdv_count += int'(m0_readdatavalid) + int'(m1_readdatavalid);
            if (c < 8) begin
                pv = 1'b1; pw = exp_win;
                pa = exp_win ? 13'(13'h200 + n1) : 13'(13'h100 + n0);
                if (exp_win) n1++; else n0++;
                exp_win = ~exp_win;
            end else begin
                pv = 1'b0;
            end
        end
        checks++;
        if (rdv_count != 8) begin
            errors++;
            $display("FAIL rr_rdv_total: got %0d expected 8", rdv_count);
        end

        // Reset right after an accepted read kills the pending response
        @(posedge clk); #1;
        m0_read = 1'b1; m0_address = 13'h0010; m0_byteenable = 4'hF;
        @(negedge clk);
        chk1("mid_cs", mem_chipselect, 1'b1);
        chk1("mid_sticky_before", oor_sticky, 1'b1);
        @(posedge clk); #1;
        idle_inputs();
        reset_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk1($sformatf("mid%0d_rdv0", k), m0_readdatavalid, 1'b0);
            chk1($sformatf("mid%0d_w0", k), m0_waitrequest, 1'b1);
            chk1($sformatf("mid%0d_sticky", k), oor_sticky, 1'b0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        chk1("post_rdv0", m0_readdatavalid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
